fto_response_checker: RTL and testbench

- Hardware response checker for the four-input combinational function block (inputs A,B,C,D; output out). It is the receiving end of the exhaustive-stimulus interface.
- It watches the applied 4-bit vector and the DUT output, waits for the vector to stay stable, then compares out against a golden truth table.
- It tracks coverage of all 16 minterms and counts mismatches. It reports done and pass once every minterm has been checked.
- It sits beside the DUT in self-test builds and replaces manual waveform inspection.

---
 rtl/fto_chk_pkg.sv | 16 +
 rtl/fto_settle_timer.sv | 57 +++++
 rtl/fto_response_checker.sv | 97 +++++++++
 tb/tb_fto_response_checker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fto_chk_pkg.sv
// Shared types and defaults for the four-input function response checker.
package fto_chk_pkg;

  localparam int unsigned VEC_W             = 4;
  localparam int unsigned NUM_MINTERMS      = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 3;
  localparam int unsigned DEF_ERR_W         = 5;
  localparam logic [NUM_MINTERMS-1:0] DEF_TRUTH_TABLE = 16'h6996;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

endpackage

// File: rtl/fto_settle_timer.sv
// Tracks how long the applied vector has been stable and fires one compare
// strobe per stable interval once SETTLE_CYCLES stable edges have elapsed.
module fto_settle_timer
  import fto_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             restart,
  input  logic             sample_en,
  input  logic [VEC_W-1:0] vec_in,
  output logic             compare_strobe,
  output logic [VEC_W-1:0] vec
);

  localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);

  logic [3:0] cnt;
  logic       checked;

  // Restart always wins so that a start pulse never coincides with a compare.
  always_comb begin
    compare_strobe = 1'b0;
    if (active && !restart && sample_en && (vec_in == vec) &&
        (cnt == SETTLE_MAX) && !checked)
      compare_strobe = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec     <= '0;
      cnt     <= '0;
      checked <= 1'b0;
    end else if (restart) begin
      vec     <= vec_in;
      cnt     <= '0;
      checked <= 1'b0;
    end else if (active) begin
      if (!sample_en) begin
        cnt     <= '0;
        checked <= 1'b0;
      end else if (vec_in != vec) begin
        vec     <= vec_in;
        cnt     <= '0;
        checked <= 1'b0;
      end else begin
        if (cnt < SETTLE_MAX)
          cnt <= cnt + 4'd1;
        if (compare_strobe)
          checked <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fto_response_checker.sv
// Compares a combinational DUT output against a golden truth table once each
// applied vector has settled, tracking minterm coverage and mismatches.
module fto_response_checker
  import fto_chk_pkg::*;
#(
  parameter logic [NUM_MINTERMS-1:0] TRUTH_TABLE   = DEF_TRUTH_TABLE,
  parameter int unsigned             SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned             ERR_W         = DEF_ERR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sample_en,
  input  logic [VEC_W-1:0]        vec_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_count,
  output logic [NUM_MINTERMS-1:0] cov_map,
  output logic [VEC_W-1:0]        first_fail_vec,
  output logic                    first_fail_valid
);

  state_t                  state;
  logic                    compare_strobe;
  logic [VEC_W-1:0]        chk_vec;
  logic                    mismatch;
  logic [ERR_W-1:0]        err_next;
  logic [NUM_MINTERMS-1:0] cov_next;

  fto_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (state == SETTLE),
    .restart       (start),
    .sample_en     (sample_en),
    .vec_in        (vec_in),
    .compare_strobe(compare_strobe),
    .vec           (chk_vec)
  );

  // Next-state values are formed here so completion can see the final compare.
  always_comb begin
    mismatch = (dut_out != TRUTH_TABLE[chk_vec]);
    err_next = err_count;
    if (mismatch && (err_count != '1))
      err_next = err_count + 1'b1;
    cov_next = cov_map | (NUM_MINTERMS'(1) << chk_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      cov_map          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start) begin
      state            <= SETTLE;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      cov_map          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (compare_strobe) begin
            cov_map   <= cov_next;
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= chk_vec;
              first_fail_valid <= 1'b1;
            end
            if (cov_next == '1) begin
              done  <= 1'b1;
              pass  <= (err_next == '0);
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        IDLE, DONE: state <= state;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fto_response_checker.sv
// Directed bench for fto_response_checker: default build plus an ERR_W=2 build
// sharing the same stimulus.
module tb_fto_response_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sample_en = 1'b0;
  logic [3:0]  vec_in = 4'd0;
  logic        dut_out = 1'b0;

  logic        busy, done, pass, first_fail_valid;
  logic [4:0]  err_count;
  logic [15:0] cov_map;
  logic [3:0]  first_fail_vec;

  logic        busy2, done2, pass2, first_fail_valid2;
  logic [1:0]  err_count2;
  logic [15:0] cov_map2;
  logic [3:0]  first_fail_vec2;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  fto_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
    .vec_in(vec_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .cov_map(cov_map), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  fto_response_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
    .vec_in(vec_in), .dut_out(dut_out), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .cov_map(cov_map2), .first_fail_vec(first_fail_vec2),
    .first_fail_valid(first_fail_valid2)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Golden model: the default truth table 16'h6996 is 4-input odd parity.
  task automatic sweep(input logic [15:0] wrong_mask, input int unsigned nvec);
    logic [3:0] v;
    for (int i = 0; i < int'(nvec); i++) begin
      v = 4'(i);
      vec_in    = v;
      sample_en = 1'b1;
      dut_out   = (^v) ^ wrong_mask[i];
      step(15);
    end
  endtask

  task automatic fresh_run();
    vec_in = 4'd0; sample_en = 1'b1; dut_out = 1'b0;
    pulse_start();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    tests_run++; if ({busy, done, pass, first_fail_valid} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got %b want 0000", {busy, done, pass, first_fail_valid}); end
    tests_run++; if (err_count !== 5'd0 || cov_map !== 16'h0 || first_fail_vec !== 4'd0) begin tests_failed++; $display("FAIL reset_data got err=%0d cov=%h ffv=%0d want 0", err_count, cov_map, first_fail_vec); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_clean_sweep();
    fresh_run();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_after_start got %b want 1", busy); end
    sweep(16'h0000, 15);
    tests_run++; if (done !== 1'b0 || cov_map !== 16'h7FFF) begin tests_failed++; $display("FAIL partial_sweep got done=%b cov=%h want done=0 cov=7fff", done, cov_map); end
    sweep(16'h0000, 16);
    tests_run++; if (cov_map !== 16'hFFFF) begin tests_failed++; $display("FAIL clean_cov got %h want ffff", cov_map); end
    tests_run++; if ({done, pass, busy, first_fail_valid} !== 4'b1100) begin tests_failed++; $display("FAIL clean_flags got %b want 1100", {done, pass, busy, first_fail_valid}); end
    tests_run++; if (err_count !== 5'd0) begin tests_failed++; $display("FAIL clean_err got %0d want 0", err_count); end
  endtask

  task automatic test_two_errors();
    fresh_run();
    sweep(16'h0220, 16);
    tests_run++; if (err_count !== 5'd2) begin tests_failed++; $display("FAIL two_err_count got %0d want 2", err_count); end
    tests_run++; if (first_fail_vec !== 4'd5 || first_fail_valid !== 1'b1) begin tests_failed++; $display("FAIL two_err_first got vec=%0d valid=%b want vec=5 valid=1", first_fail_vec, first_fail_valid); end
    tests_run++; if (done !== 1'b1 || pass !== 1'b0) begin tests_failed++; $display("FAIL two_err_flags got done=%b pass=%b want done=1 pass=0", done, pass); end
  endtask

  task automatic test_glitch_latency();
    fresh_run();
    step(15);
    vec_in = 4'd3; dut_out = 1'b0;
    step(2);
    vec_in = 4'd4; dut_out = 1'b1;
    step(1);
    step(3);
    tests_run++; if (cov_map[4] !== 1'b0) begin tests_failed++; $display("FAIL latency_early got cov4=%b want 0", cov_map[4]); end
    step(1);
    tests_run++; if (cov_map !== 16'h0011) begin tests_failed++; $display("FAIL glitch_cov got %h want 0011", cov_map); end
    tests_run++; if (err_count !== 5'd0) begin tests_failed++; $display("FAIL glitch_err got %0d want 0", err_count); end
  endtask

  task automatic test_hold_and_recheck();
    vec_in = 4'd7; sample_en = 1'b1; dut_out = 1'b0;
    pulse_start();
    step(50);
    tests_run++; if (err_count !== 5'd1 || cov_map !== 16'h0080) begin tests_failed++; $display("FAIL hold_once got err=%0d cov=%h want err=1 cov=0080", err_count, cov_map); end
    tests_run++; if (first_fail_vec !== 4'd7 || first_fail_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_first got vec=%0d valid=%b want 7 1", first_fail_vec, first_fail_valid); end
    sample_en = 1'b0;
    step(1);
    sample_en = 1'b1;
    step(3);
    tests_run++; if (err_count !== 5'd1) begin tests_failed++; $display("FAIL recheck_early got %0d want 1", err_count); end
    step(1);
    tests_run++; if (err_count !== 5'd2 || cov_map !== 16'h0080) begin tests_failed++; $display("FAIL recheck got err=%0d cov=%h want err=2 cov=0080", err_count, cov_map); end
  endtask

  task automatic test_saturation();
    fresh_run();
    sweep(16'hFFFF, 16);
    tests_run++; if (err_count2 !== 2'd3) begin tests_failed++; $display("FAIL sat_err got %0d want 3", err_count2); end
    tests_run++; if (first_fail_vec2 !== 4'd0 || done2 !== 1'b1 || pass2 !== 1'b0) begin tests_failed++; $display("FAIL sat_flags got ffv=%0d done=%b pass=%b want 0 1 0", first_fail_vec2, done2, pass2); end
    tests_run++; if (err_count !== 5'd16) begin tests_failed++; $display("FAIL wide_err got %0d want 16", err_count); end
  endtask

  task automatic test_start_wins();
    vec_in = 4'd2; sample_en = 1'b1; dut_out = 1'b1;
    pulse_start();
    step(3);
    pulse_start();
    tests_run++; if (cov_map !== 16'h0000) begin tests_failed++; $display("FAIL start_wins got %h want 0000", cov_map); end
    step(3);
    tests_run++; if (cov_map !== 16'h0000) begin tests_failed++; $display("FAIL restart_early got %h want 0000", cov_map); end
    step(1);
    tests_run++; if (cov_map !== 16'h0004) begin tests_failed++; $display("FAIL restart_cov got %h want 0004", cov_map); end
  endtask

  task automatic test_reset_mid_run();
    fresh_run();
    sweep(16'h0001, 8);
    rst_n = 1'b0;
    #2;
    tests_run++; if ({busy, done, pass, first_fail_valid} !== 4'b0000 || cov_map !== 16'h0 || err_count !== 5'd0) begin tests_failed++; $display("FAIL async_reset got flags=%b cov=%h err=%0d want 0", {busy, done, pass, first_fail_valid}, cov_map, err_count); end
    step(1);
    rst_n = 1'b1;
    step(1);
    fresh_run();
    sweep(16'h0000, 16);
    tests_run++; if (done !== 1'b1 || pass !== 1'b1 || cov_map !== 16'hFFFF) begin tests_failed++; $display("FAIL post_reset_pass got done=%b pass=%b cov=%h want 1 1 ffff", done, pass, cov_map); end
    step(5);
    tests_run++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL done_hold got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy); end
    pulse_start();
    tests_run++; if (done !== 1'b0 || pass !== 1'b0 || cov_map !== 16'h0 || busy !== 1'b1) begin tests_failed++; $display("FAIL restart_from_done got done=%b pass=%b cov=%h busy=%b want 0 0 0000 1", done, pass, cov_map, busy); end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_two_errors();
    test_glitch_latency();
    test_hold_and_recheck();
    test_saturation();
    test_start_wins();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
